// File: rtl/ahb_slv_mem.sv
// rtl/ahb_slv_mem.sv - AHB slave with word-addressed scratch memory, wait states and ERROR responses
// Optional AHB_SLV_RAND_WAIT_EN: per-transfer wait count from a 16-bit LFSR, clamped to 0..WAIT_CYC
module ahb_slv_mem #(
    parameter int SLV_AW   = 32,
    parameter int DEPTH    = 1024,
    parameter int WAIT_CYC = 0
) (
    input  logic              hclk,
    input  logic              hrest,
    input  logic              hsel,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [SLV_AW-1:0] haddr,
    input  logic [31:0]       hwdata,
    input  logic              hready_in,
    output logic              hready_out,
    output logic [1:0]        hresp,
    output logic [31:0]       hrdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t            state;
    logic [31:0]       mem [DEPTH];
    logic [IDX_W-1:0]  lat_idx;
    logic [1:0]        lat_off;
    logic [2:0]        lat_size;
    logic              lat_write;
    logic [3:0]        wait_cnt;
    logic [3:0]        wait_val;

    logic              sample;
    logic              illegal;
    logic [SLV_AW-1:0] addr_word;
    logic [IDX_W-1:0]  s_idx;
    logic              wr_en;
    logic [3:0]        wr_be;
    logic [31:0]       fwd_word;

    function automatic logic [3:0] lane_en(input logic [2:0] size, input logic [1:0] off);
        case (size)
            3'd0:    lane_en = 4'b0001 << off;
            3'd1:    lane_en = off[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    endfunction

    assign addr_word = haddr >> 2;
    assign s_idx     = haddr[IDX_W+1:2];
    assign sample    = hsel && htrans[1] && hready_in &&
                       (state == ST_IDLE || state == ST_DATA || state == ST_ERR2);
    assign illegal   = (addr_word >= SLV_AW'(DEPTH)) || (hsize > 3'd2) ||
                       (hsize == 3'd1 && haddr[0]) ||
                       (hsize == 3'd2 && haddr[1:0] != 2'b00);
    assign wr_en     = (state == ST_DATA) && lat_write;
    assign wr_be     = lane_en(lat_size, lat_off);

`ifdef AHB_SLV_RAND_WAIT_EN
    logic [15:0] lfsr;

    always_ff @(posedge hclk) begin
        if (hrest) begin
            lfsr <= 16'hACE1;
        end else if (sample) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign wait_val = (lfsr[3:0] > 4'(WAIT_CYC)) ? 4'(WAIT_CYC) : lfsr[3:0];
`else
    assign wait_val = 4'(WAIT_CYC);
`endif

    // A zero-wait read following a write to the same word must see the bytes committed on this edge
    always_comb begin
        fwd_word = mem[s_idx];
        if (wr_en && lat_idx == s_idx) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) fwd_word[8*i +: 8] = hwdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (!hrest && wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[lat_idx][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hrest) begin
            state      <= ST_IDLE;
            hready_out <= 1'b1;
            hresp      <= 2'd0;
            hrdata     <= 32'd0;
            lat_idx    <= '0;
            lat_off    <= 2'd0;
            lat_size   <= 3'd0;
            lat_write  <= 1'b0;
            wait_cnt   <= 4'd0;
        end else begin
            hrdata <= 32'd0;
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state      <= ST_DATA;
                        hready_out <= 1'b1;
                        hresp      <= 2'd0;
                        if (!lat_write) hrdata <= mem[lat_idx];
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state      <= ST_ERR2;
                    hready_out <= 1'b1;
                    hresp      <= 2'd1;
                end
                default: begin
                    if (sample) begin
                        lat_idx  <= s_idx;
                        lat_off  <= haddr[1:0];
                        lat_size <= hsize;
                        if (illegal) begin
                            state      <= ST_ERR1;
                            lat_write  <= 1'b0;
                            hready_out <= 1'b0;
                            hresp      <= 2'd1;
                        end else if (wait_val != 4'd0) begin
                            state      <= ST_WAIT;
                            lat_write  <= hwrite;
                            wait_cnt   <= wait_val - 4'd1;
                            hready_out <= 1'b0;
                            hresp      <= 2'd0;
                        end else begin
                            state      <= ST_DATA;
                            lat_write  <= hwrite;
                            hready_out <= 1'b1;
                            hresp      <= 2'd0;
                            if (!hwrite) hrdata <= fwd_word;
                        end
                    end else begin
                        state      <= ST_IDLE;
                        lat_write  <= 1'b0;
                        hready_out <= 1'b1;
                        hresp      <= 2'd0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_slv_mem.sv
// tb/tb_ahb_slv_mem.sv - directed bench for ahb_slv_mem with zero-wait and three-wait instances
module tb_ahb_slv_mem;

    logic        hclk = 1'b0;
    logic        hrest;
    logic        hsel0, hsel3;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        rdy0, rdy3;
    logic [1:0]  resp0, resp3;
    logic [31:0] rd0, rd3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 hclk = ~hclk;

    ahb_slv_mem #(.SLV_AW(32), .DEPTH(64), .WAIT_CYC(0)) u_dut0 (
        .hclk(hclk), .hrest(hrest), .hsel(hsel0), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hready_in(rdy0),
        .hready_out(rdy0), .hresp(resp0), .hrdata(rd0)
    );

    ahb_slv_mem #(.SLV_AW(32), .DEPTH(64), .WAIT_CYC(3)) u_dut3 (
        .hclk(hclk), .hrest(hrest), .hsel(hsel3), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hready_in(rdy3),
        .hready_out(rdy3), .hresp(resp3), .hrdata(rd3)
    );

    typedef struct {
        string       name;
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rdy;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic sel, input logic [1:0] trans,
                                input logic wr, input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic rdy, input logic [1:0] resp,
                                input logic [31:0] rdata);
        vec_t v;
        v.name = name; v.sel = sel; v.trans = trans; v.wr = wr; v.size = size;
        v.addr = addr; v.wdata = wdata; v.rdy = rdy; v.resp = resp; v.rdata = rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic a_rdy, input logic [1:0] a_resp,
                         input logic [31:0] a_rd, input logic e_rdy, input logic [1:0] e_resp,
                         input logic [31:0] e_rd);
        n_tests++;
        if ({a_rdy, a_resp, a_rd} !== {e_rdy, e_resp, e_rd}) begin
            n_fail++;
            $display("FAIL %s: got rdy=%0b resp=%0d rdata=%h, expected rdy=%0b resp=%0d rdata=%h",
                     name, a_rdy, a_resp, a_rd, e_rdy, e_resp, e_rd);
        end
    endtask

    task automatic drv(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        hsel3 = sel; htrans = trans; hwrite = wr; hsize = size; haddr = addr; hwdata = wdata;
    endtask

    task automatic cyc3(input string name, input logic e_rdy, input logic [1:0] e_resp,
                        input logic [31:0] e_rd);
        @(posedge hclk);
        #1;
        check(name, rdy3, resp3, rd3, e_rdy, e_resp, e_rd);
    endtask

    initial begin
        // Each row: bus inputs for the coming edge, and outputs expected in the current cycle
        vecs.push_back(mk("idle0",     1, 0, 0, 2, 32'h00, 32'h0,        1, 0, 32'h0));
        vecs.push_back(mk("wr00",      1, 2, 1, 2, 32'h00, 32'h0,        1, 0, 32'h0));
        vecs.push_back(mk("wr10",      1, 2, 1, 2, 32'h10, 32'h12345678, 1, 0, 32'h0));
        vecs.push_back(mk("rd10",      1, 2, 0, 2, 32'h10, 32'hDEADBEEF, 1, 0, 32'h0));
        vecs.push_back(mk("rd10_data", 1, 0, 0, 2, 32'h00, 32'h0,        1, 0, 32'hDEADBEEF));
        vecs.push_back(mk("wrb20",     1, 2, 1, 0, 32'h20, 32'h0,        1, 0, 32'h0));
        vecs.push_back(mk("wrb21",     1, 3, 1, 0, 32'h21, 32'h00000011, 1, 0, 32'h0));
        vecs.push_back(mk("wrh22",     1, 3, 1, 1, 32'h22, 32'h00002200, 1, 0, 32'h0));
        vecs.push_back(mk("rd20",      1, 2, 0, 2, 32'h20, 32'h44330000, 1, 0, 32'h0));
        vecs.push_back(mk("rd20_data", 1, 0, 0, 2, 32'h00, 32'h0,        1, 0, 32'h44332211));
        vecs.push_back(mk("rd_oor",    1, 2, 0, 2, 32'h100, 32'h0,       1, 0, 32'h0));
        vecs.push_back(mk("oor_err1",  1, 0, 0, 2, 32'h00, 32'h0,        0, 1, 32'h0));
        vecs.push_back(mk("wr_unal",   1, 2, 1, 2, 32'h02, 32'h0,        1, 1, 32'h0));
        vecs.push_back(mk("unal_err1", 1, 0, 0, 2, 32'h00, 32'hFFFFFFFF, 0, 1, 32'h0));
        vecs.push_back(mk("unal_err2", 1, 0, 0, 2, 32'h00, 32'hFFFFFFFF, 1, 1, 32'h0));
        vecs.push_back(mk("rd00",      1, 2, 0, 2, 32'h00, 32'h0,        1, 0, 32'h0));
        vecs.push_back(mk("busy",      1, 1, 1, 2, 32'h00, 32'h0,        1, 0, 32'h12345678));
        vecs.push_back(mk("desel",     0, 2, 1, 2, 32'h00, 32'hBAD0BAD0, 1, 0, 32'h0));
        vecs.push_back(mk("idle_wr",   1, 0, 1, 2, 32'h00, 32'hBAD0BAD0, 1, 0, 32'h0));
        vecs.push_back(mk("rd00b",     1, 2, 0, 2, 32'h00, 32'hBAD0BAD0, 1, 0, 32'h0));
        vecs.push_back(mk("wrh_odd",   1, 2, 1, 1, 32'h21, 32'h0,        1, 0, 32'h12345678));
        vecs.push_back(mk("odd_err1",  1, 0, 0, 2, 32'h00, 32'h0000FFFF, 0, 1, 32'h0));
        vecs.push_back(mk("odd_err2",  1, 0, 0, 2, 32'h00, 32'h0000FFFF, 1, 1, 32'h0));
        vecs.push_back(mk("rd20b",     1, 2, 0, 2, 32'h20, 32'h0,        1, 0, 32'h0));
        vecs.push_back(mk("rd20b_dat", 1, 0, 0, 2, 32'h00, 32'h0,        1, 0, 32'h44332211));

        hrest = 1'b1;
        hsel0 = 1'b0; hsel3 = 1'b0; htrans = 2'd0; hwrite = 1'b0;
        hsize = 3'd2; haddr = 32'h0; hwdata = 32'h0;
        repeat (2) @(posedge hclk);
        #1;
        hrest = 1'b0;
        check("reset0", rdy0, resp0, rd0, 1'b1, 2'd0, 32'h0);
        check("reset3", rdy3, resp3, rd3, 1'b1, 2'd0, 32'h0);

        foreach (vecs[i]) begin
            @(posedge hclk);
            #1;
            check(vecs[i].name, rdy0, resp0, rd0, vecs[i].rdy, vecs[i].resp, vecs[i].rdata);
            hsel0  = vecs[i].sel;
            htrans = vecs[i].trans;
            hwrite = vecs[i].wr;
            hsize  = vecs[i].size;
            haddr  = vecs[i].addr;
            hwdata = vecs[i].wdata;
        end
        @(posedge hclk);
        #1;
        hsel0 = 1'b0;
        htrans = 2'd0;

        // Three-wait instance: write, read with wait count, reset mid-wait
        cyc3("w3_idle", 1, 0, 32'h0);
        drv(1, 2, 1, 2, 32'h30, 32'h0);
        cyc3("w3_wait0", 0, 0, 32'h0);
        drv(1, 0, 0, 2, 32'h0, 32'hCAFEF00D);
        cyc3("w3_wait1", 0, 0, 32'h0);
        cyc3("w3_wait2", 0, 0, 32'h0);
        cyc3("w3_data", 1, 0, 32'h0);
        drv(1, 2, 0, 2, 32'h30, 32'hCAFEF00D);
        cyc3("r3_wait0", 0, 0, 32'h0);
        drv(1, 0, 0, 2, 32'h0, 32'h0);
        cyc3("r3_wait1", 0, 0, 32'h0);
        cyc3("r3_wait2", 0, 0, 32'h0);
        cyc3("r3_data", 1, 0, 32'hCAFEF00D);
        drv(1, 2, 1, 2, 32'h30, 32'h0);
        cyc3("rw_wait0", 0, 0, 32'h0);
        drv(1, 0, 0, 2, 32'h0, 32'h55555555);
        hrest = 1'b1;
        cyc3("rst_after", 1, 0, 32'h0);
        hrest = 1'b0;
        drv(1, 2, 0, 2, 32'h30, 32'h0);
        cyc3("r3b_wait0", 0, 0, 32'h0);
        drv(1, 0, 0, 2, 32'h0, 32'h0);
        cyc3("r3b_wait1", 0, 0, 32'h0);
        cyc3("r3b_wait2", 0, 0, 32'h0);
        cyc3("r3b_data", 1, 0, 32'hCAFEF00D);
        cyc3("r3b_idle", 1, 0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
